intr_ctrl: RTL and testbench
============================

INTR_CTRL -- requirements
Module: intr_ctrl

Interface
REQ-001 Parameter NUM_IRQ, default 8: number of interrupt request lines.
REQ-002 Parameter ISR_BASE, default 12'd3840: lowest PC address of interrupt service code.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 irq_in  input  NUM_IRQ  level request lines, already synchronous to clk.
REQ-006 dec_code  input  4  branch/stack control code from the instruction decoder.
REQ-007 pc_in  input  12  current PC from the PC/SP/stack unit.
REQ-008 mask_we  input  1  write strobe for the mask register.
REQ-009 mask_wdata  input  NUM_IRQ  mask write data; 1 enables the line.
REQ-010 gie_we  input  1  write strobe for the global interrupt enable.
REQ-011 gie_wdata  input  1  global interrupt enable write data.
REQ-012 code_out  output  4  control code driven to the PC/SP/stack unit.
REQ-013 irq_id  output  3  index of the interrupt currently in service.
REQ-014 in_service  output  1  high while an ISR is executing.
REQ-015 pending  output  NUM_IRQ  latched pending requests.

Function
REQ-016 Rising edges on irq_in are detected against a one-cycle-delayed copy irq_q; edge = irq_in & ~irq_q.
REQ-017 Each detected edge sets its pending bit at the next clock edge, regardless of the mask or GIE state.
REQ-018 The mask gates only selection; masked pending bits remain latched until unmasked and serviced.
REQ-019 Selection is by fixed priority: the lowest-index bit of (pending & mask) wins.
REQ-020 The FSM has two states: IDLE and ISR.
REQ-021 An injection is taken in the same cycle (combinational) when: state IDLE, gie=1, (pending & mask)!=0, dec_code=4'b1000 (STEP), and pc_in < ISR_BASE.
REQ-022 In an injection cycle, code_out = 4'b0111 (INTR); in all other cycles, code_out = dec_code unchanged.
REQ-023 At the clock edge ending an injection cycle: state becomes ISR, in_service=1, irq_id latches the winner index, and the winner's pending bit clears.
REQ-024 If a new edge on the winning line coincides with its clear, the set wins and the bit stays pending.
REQ-025 In ISR, no further injection occurs (no nesting); edges continue to latch into pending.
REQ-026 In ISR, dec_code=4'b0100 (RET) with pc_in >= ISR_BASE returns the FSM to IDLE at the next edge, clears in_service, and leaves irq_id holding its last value.
REQ-027 A RET with pc_in < ISR_BASE is passed through and does not change the state.
REQ-028 A mask or GIE write takes effect at the next edge; a write coinciding with an injection does not cancel that injection.
REQ-029 pending, irq_id and in_service are registered outputs.

Reset
REQ-030 On rst=1 at a clock edge: state=IDLE, pending=0, mask=0, gie=0, irq_id=0, in_service=0, irq_q=all ones.
REQ-031 irq_q resets to all ones so that lines held high through reset do not generate an edge.
REQ-032 Reset asserted mid-ISR aborts service immediately; code_out is pass-through during and after reset.

Structure
REQ-033 A shared package holds the code constants: JMP=4'b0000, RET=4'b0100, INTR=4'b0111, STEP=4'b1000, NOP=4'b1001; it also holds ISR_BASE and the NUM_IRQ default.
REQ-034 A single sub-module, intr_prio_enc, implements the combinational fixed-priority encoder (NUM_IRQ in, valid plus index out).

Verification
REQ-035 Reset test: apply reset with mask=8'hFF, gie=1, irq_in=8'h01 held high -> no pending bit and no INTR.
REQ-036 Single-request test: irq_in[3] rises, mask=8'h08, gie=1, dec_code=STEP, pc_in=12'h010 -> pending=8'h08 one cycle later, then code_out=0111, in the next cycle irq_id=3, in_service=1, pending=0.
REQ-037 Priority and masking test: edges on bits 5 and 2 together, mask=8'h20 -> line 5 is serviced and pending[2] remains 1.
REQ-038 No-nesting and return test: in ISR, irq_in[0] rises -> pending[0]=1 with no INTR; then RET with pc_in=12'hF05 -> the next cycle is IDLE, and line 0 is injected on the next STEP.
REQ-039 Gating test: gie=0 or dec_code=0001 (JSR) or pc_in=12'hF00 while pending -> code_out equals dec_code and there is no state change.
REQ-040 Set-wins test: an edge on the winning line in the injection cycle -> that pending bit is still 1 after the injection.

Source files
------------

// File: rtl/intr_ctrl_pkg.sv
// Shared constants for the interrupt controller: decoder control codes,
// default parameters and the service FSM state type.
package intr_ctrl_pkg;

   localparam int unsigned NUM_IRQ_DEF  = 8;
   localparam logic [11:0] ISR_BASE_DEF = 12'd3840;

   localparam logic [3:0] CODE_JMP  = 4'b0000;
   localparam logic [3:0] CODE_RET  = 4'b0100;
   localparam logic [3:0] CODE_INTR = 4'b0111;
   localparam logic [3:0] CODE_STEP = 4'b1000;
   localparam logic [3:0] CODE_NOP  = 4'b1001;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_ISR  = 1'b1
   } state_t;

endpackage

// File: rtl/intr_prio_enc.sv
// Fixed-priority encoder: the lowest-index asserted request wins.
module intr_prio_enc #(
   parameter int unsigned NUM_IRQ = 8,
   parameter int unsigned IDX_W   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
   input  logic [NUM_IRQ-1:0] req,
   output logic               valid,
   output logic [IDX_W-1:0]   idx
);

   // Scan from the top down so the lowest set bit is the last assignment.
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      for (int unsigned i = NUM_IRQ; i > 0; i--) begin
         if (req[i-1]) begin
            valid = 1'b1;
            idx   = IDX_W'(i - 1);
         end
      end
   end

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller: latches request edges, and injects an INTR code into
// the PC/SP/stack control stream on a STEP outside service code.
module intr_ctrl
   import intr_ctrl_pkg::*;
#(
   parameter int unsigned NUM_IRQ  = NUM_IRQ_DEF,
   parameter logic [11:0] ISR_BASE = ISR_BASE_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_IRQ-1:0] irq_in,
   input  logic [3:0]         dec_code,
   input  logic [11:0]        pc_in,
   input  logic               mask_we,
   input  logic [NUM_IRQ-1:0] mask_wdata,
   input  logic               gie_we,
   input  logic               gie_wdata,
   output logic [3:0]         code_out,
   output logic [2:0]         irq_id,
   output logic               in_service,
   output logic [NUM_IRQ-1:0] pending
);

   localparam int unsigned IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

   state_t             state_q, state_d;
   logic [NUM_IRQ-1:0] pending_q, pending_d;
   logic [NUM_IRQ-1:0] mask_q, mask_d;
   logic [NUM_IRQ-1:0] irq_q, irq_d;
   logic               gie_q, gie_d;
   logic [2:0]         irq_id_q, irq_id_d;
   logic               in_service_q, in_service_d;

   logic [NUM_IRQ-1:0] sel_req;
   logic [NUM_IRQ-1:0] rise;
   logic               enc_valid;
   logic [IDX_W-1:0]   win_idx;
   logic               inject;
   logic               ret_ok;

   assign sel_req = pending_q & mask_q;

   intr_prio_enc #(
      .NUM_IRQ (NUM_IRQ),
      .IDX_W   (IDX_W)
   ) u_prio_enc (
      .req   (sel_req),
      .valid (enc_valid),
      .idx   (win_idx)
   );

   always_comb begin
      rise   = irq_in & ~irq_q;
      // Reset forces pass-through even if stale pending state would inject.
      inject = !rst && (state_q == ST_IDLE) && gie_q && enc_valid &&
               (dec_code == CODE_STEP) && (pc_in < ISR_BASE);
      ret_ok = (state_q == ST_ISR) && (dec_code == CODE_RET) && (pc_in >= ISR_BASE);

      code_out     = inject ? CODE_INTR : dec_code;
      state_d      = state_q;
      pending_d    = pending_q;
      irq_id_d     = irq_id_q;
      in_service_d = in_service_q;
      irq_d        = irq_in;
      mask_d       = mask_we ? mask_wdata : mask_q;
      gie_d        = gie_we ? gie_wdata : gie_q;

      if (inject) begin
         state_d            = ST_ISR;
         in_service_d       = 1'b1;
         irq_id_d           = 3'(win_idx);
         pending_d[win_idx] = 1'b0;
      end else if (ret_ok) begin
         state_d      = ST_IDLE;
         in_service_d = 1'b0;
      end

      // Applied after the clear so a coinciding edge keeps the bit pending.
      pending_d = pending_d | rise;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         pending_q    <= '0;
         mask_q       <= '0;
         gie_q        <= 1'b0;
         irq_id_q     <= '0;
         in_service_q <= 1'b0;
         irq_q        <= '1;
      end else begin
         state_q      <= state_d;
         pending_q    <= pending_d;
         mask_q       <= mask_d;
         gie_q        <= gie_d;
         irq_id_q     <= irq_id_d;
         in_service_q <= in_service_d;
         irq_q        <= irq_d;
      end
   end

   assign pending    = pending_q;
   assign irq_id     = irq_id_q;
   assign in_service = in_service_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Bench for intr_ctrl: a directed vector table for the documented scenarios,
// then randomized traffic checked against a behavioural model.
module tb_intr_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  irq_in;
   logic [3:0]  dec_code;
   logic [11:0] pc_in;
   logic        mask_we;
   logic [7:0]  mask_wdata;
   logic        gie_we;
   logic        gie_wdata;
   logic [3:0]  code_out;
   logic [2:0]  irq_id;
   logic        in_service;
   logic [7:0]  pending;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   intr_ctrl #(
      .NUM_IRQ  (8),
      .ISR_BASE (12'd3840)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .irq_in     (irq_in),
      .dec_code   (dec_code),
      .pc_in      (pc_in),
      .mask_we    (mask_we),
      .mask_wdata (mask_wdata),
      .gie_we     (gie_we),
      .gie_wdata  (gie_wdata),
      .code_out   (code_out),
      .irq_id     (irq_id),
      .in_service (in_service),
      .pending    (pending)
   );

   typedef struct {
      logic        rst;
      logic [7:0]  irq;
      logic [3:0]  code;
      logic [11:0] pc;
      logic        mwe;
      logic [7:0]  mdat;
      logic        gwe;
      logic        gdat;
      logic [3:0]  exp_code;
      logic [7:0]  exp_pend;
      logic [2:0]  exp_id;
      logic        exp_isr;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic r, input logic [7:0] irq, input logic [3:0] code,
                               input logic [11:0] pc, input logic mwe, input logic [7:0] mdat,
                               input logic gwe, input logic gdat, input logic [3:0] ec,
                               input logic [7:0] ep, input logic [2:0] ei, input logic es);
      vec_t v;
      v.rst = r; v.irq = irq; v.code = code; v.pc = pc;
      v.mwe = mwe; v.mdat = mdat; v.gwe = gwe; v.gdat = gdat;
      v.exp_code = ec; v.exp_pend = ep; v.exp_id = ei; v.exp_isr = es;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic [7:0] irq, input logic [3:0] code,
                        input logic [11:0] pc, input logic mwe, input logic [7:0] mdat,
                        input logic gwe, input logic gdat);
      rst = r; irq_in = irq; dec_code = code; pc_in = pc;
      mask_we = mwe; mask_wdata = mdat; gie_we = gwe; gie_wdata = gdat;
   endtask

   // Behavioural reference model state
   bit       m_isr;
   bit [7:0] m_pend, m_mask, m_prev;
   bit       m_gie;
   int       m_id;

   task automatic model_reset();
      m_isr = 0; m_pend = 0; m_mask = 0; m_gie = 0; m_id = 0; m_prev = 8'hFF;
   endtask

   initial begin
      // rst irq   code  pc      mwe mdat  gwe gd  exp_code pend  id isr
      tbl.push_back(mk(1, 8'h00, 4'h8, 12'h010, 0, 8'h00, 0, 0, 4'h8, 8'h00, 0, 0));
      tbl.push_back(mk(0, 8'h01, 4'h8, 12'h010, 1, 8'hFF, 1, 1, 4'h8, 8'h00, 0, 0));
      tbl.push_back(mk(0, 8'h01, 4'h8, 12'h010, 0, 8'h00, 0, 0, 4'h8, 8'h00, 0, 0));
      tbl.push_back(mk(0, 8'h08, 4'h9, 12'h010, 1, 8'h08, 0, 0, 4'h9, 8'h08, 0, 0));
      tbl.push_back(mk(0, 8'h08, 4'h8, 12'h010, 0, 8'h00, 0, 0, 4'h7, 8'h00, 3, 1));
      tbl.push_back(mk(0, 8'h08, 4'h4, 12'hF05, 0, 8'h00, 0, 0, 4'h4, 8'h00, 3, 0));
      tbl.push_back(mk(0, 8'h24, 4'h9, 12'h010, 1, 8'h20, 0, 0, 4'h9, 8'h24, 3, 0));
      tbl.push_back(mk(0, 8'h24, 4'h8, 12'h010, 0, 8'h00, 0, 0, 4'h7, 8'h04, 5, 1));
      tbl.push_back(mk(0, 8'h25, 4'h8, 12'hF01, 0, 8'h00, 0, 0, 4'h8, 8'h05, 5, 1));
      tbl.push_back(mk(0, 8'h25, 4'h4, 12'h010, 0, 8'h00, 0, 0, 4'h4, 8'h05, 5, 1));
      tbl.push_back(mk(0, 8'h25, 4'h4, 12'hF05, 0, 8'h00, 0, 0, 4'h4, 8'h05, 5, 0));
      tbl.push_back(mk(0, 8'h25, 4'h9, 12'h010, 1, 8'h01, 0, 0, 4'h9, 8'h05, 5, 0));
      tbl.push_back(mk(0, 8'h25, 4'h9, 12'h010, 0, 8'h00, 1, 0, 4'h9, 8'h05, 5, 0));
      tbl.push_back(mk(0, 8'h25, 4'h8, 12'h010, 0, 8'h00, 0, 0, 4'h8, 8'h05, 5, 0));
      tbl.push_back(mk(0, 8'h25, 4'h1, 12'h010, 0, 8'h00, 1, 1, 4'h1, 8'h05, 5, 0));
      tbl.push_back(mk(0, 8'h25, 4'h1, 12'h010, 0, 8'h00, 0, 0, 4'h1, 8'h05, 5, 0));
      tbl.push_back(mk(0, 8'h25, 4'h8, 12'hF00, 0, 8'h00, 0, 0, 4'h8, 8'h05, 5, 0));
      tbl.push_back(mk(0, 8'h25, 4'h8, 12'h010, 0, 8'h00, 1, 0, 4'h7, 8'h04, 0, 1));
      tbl.push_back(mk(0, 8'h25, 4'h4, 12'hFFF, 0, 8'h00, 0, 0, 4'h4, 8'h04, 0, 0));
      tbl.push_back(mk(0, 8'h27, 4'h9, 12'h010, 1, 8'h02, 1, 1, 4'h9, 8'h06, 0, 0));
      tbl.push_back(mk(0, 8'h25, 4'h9, 12'h010, 0, 8'h00, 0, 0, 4'h9, 8'h06, 0, 0));
      tbl.push_back(mk(0, 8'h27, 4'h8, 12'h010, 0, 8'h00, 0, 0, 4'h7, 8'h06, 1, 1));
      tbl.push_back(mk(1, 8'h27, 4'h8, 12'h010, 0, 8'h00, 0, 0, 4'h8, 8'h00, 0, 0));
      // Pending line set up in IDLE, then reset with a STEP: must pass through
      tbl.push_back(mk(0, 8'h00, 4'h9, 12'h010, 1, 8'hFF, 1, 1, 4'h9, 8'h00, 0, 0));
      tbl.push_back(mk(0, 8'h01, 4'h9, 12'h010, 0, 8'h00, 0, 0, 4'h9, 8'h01, 0, 0));
      tbl.push_back(mk(1, 8'h01, 4'h8, 12'h010, 0, 8'h00, 0, 0, 4'h8, 8'h00, 0, 0));

      foreach (tbl[i]) begin
         drive(tbl[i].rst, tbl[i].irq, tbl[i].code, tbl[i].pc,
               tbl[i].mwe, tbl[i].mdat, tbl[i].gwe, tbl[i].gdat);
         #1;
         chk($sformatf("vec%0d code_out", i), 32'(code_out), 32'(tbl[i].exp_code));
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d pending", i), 32'(pending), 32'(tbl[i].exp_pend));
         chk($sformatf("vec%0d irq_id", i), 32'(irq_id), 32'(tbl[i].exp_id));
         chk($sformatf("vec%0d in_service", i), 32'(in_service), 32'(tbl[i].exp_isr));
      end

      // Randomized phase: the last vector left the DUT in reset state.
      model_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         logic        r;
         logic [7:0]  irq;
         logic [3:0]  code;
         logic [11:0] pc;
         logic        mwe, gwe, gdat, take;
         logic [7:0]  mdat, rises, masked;
         int          w, sel;

         r   = ($urandom_range(0, 99) == 0);
         irq = (cyc == 0) ? 8'h00 : irq_in ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
         sel = $urandom_range(0, 9);
         code = (sel < 5) ? 4'h8 : (sel < 7) ? 4'h4 : (sel == 7) ? 4'h9 : 4'($urandom);
         pc  = $urandom_range(0, 1) ? 12'($urandom_range(0, 12'hEFF))
                                    : 12'($urandom_range(12'hF00, 12'hFFF));
         mwe  = ($urandom_range(0, 7) == 0);
         mdat = 8'($urandom);
         gwe  = ($urandom_range(0, 5) == 0);
         gdat = ($urandom_range(0, 3) != 0);

         masked = m_pend & m_mask;
         w = -1;
         for (int b = 7; b >= 0; b--) if (masked[b]) w = b;
         take = !r && !m_isr && m_gie && (w >= 0) && (code == 4'h8) && (int'(pc) < 3840);

         drive(r, irq, code, pc, mwe, mdat, gwe, gdat);
         #1;
         chk("rand code_out", 32'(code_out), take ? 32'h7 : 32'(code));
         @(posedge clk);

         if (r) begin
            model_reset();
         end else begin
            rises = irq & ~m_prev;
            if (take) begin
               m_pend[w] = 1'b0;
               m_isr = 1;
               m_id = w;
            end else if (m_isr && code == 4'h4 && int'(pc) >= 3840) begin
               m_isr = 0;
            end
            m_pend = m_pend | rises;
            if (mwe) m_mask = mdat;
            if (gwe) m_gie = gdat;
            m_prev = irq;
         end

         #1;
         chk("rand pending", 32'(pending), 32'(m_pend));
         chk("rand irq_id", 32'(irq_id), 32'(m_id));
         chk("rand in_service", 32'(in_service), 32'(m_isr));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
